// File: rtl/arc_run_ctrl.sv
// arc_run_ctrl: run/halt/wake sequencer driving the core request lines with ack handshake and timeout
module arc_run_ctrl #(
  parameter bit AUTO_RUN = 1'b1,
  parameter int RST_DLY  = 16,
  parameter int TMO_W    = 12,
  parameter int TMO_CYC  = 2048,
  parameter int WAKE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_cmd,
  input  logic       run_cmd,
  input  logic       wake_cmd,
  input  logic       clr_err,
  input  logic       arc_halt_ack,
  input  logic       arc_run_ack,
  input  logic       sys_halt_r,
  input  logic       sys_sleep_r,
  output logic       arc_halt_req_a,
  output logic       arc_run_req_a,
  output logic       arc_wake_evt_a,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    RST_WAIT     = 3'd0,
    IDLE         = 3'd1,
    HALT_REQ     = 3'd2,
    RUN_REQ      = 3'd3,
    ACK_WAIT_LOW = 3'd4
  } state_t;
  state_t           state_q, state_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]       wake_cnt_q, wake_cnt_d;
  logic             pend_halt_q, pend_halt_d, pend_run_q, pend_run_d;
  logic             is_halt_q, is_halt_d, halt_req_q, halt_req_d, run_req_q, run_req_d;
  logic             done_q, done_d, err_q, err_d;
  logic             halt_go, run_go, ack, tmo, in_req;
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    is_halt_d   = is_halt_q;
    done_d      = 1'b0;
    halt_go     = halt_cmd | pend_halt_q;
    run_go      = run_cmd | pend_run_q;
    ack         = is_halt_q ? arc_halt_ack : arc_run_ack;
    tmo         = tmo_cnt_q == TMO_W'(TMO_CYC);
    in_req      = state_q == HALT_REQ || state_q == RUN_REQ;
    pend_halt_d = pend_halt_q | halt_cmd;
    pend_run_d  = (pend_run_q | run_cmd) & ~(state_q == RUN_REQ && halt_cmd);
    case (state_q)
      RST_WAIT: begin
        rst_cnt_d = rst_cnt_q + 8'd1;
        if (!AUTO_RUN || rst_cnt_q == 8'(RST_DLY - 1)) begin
          state_d   = (AUTO_RUN && sys_halt_r) ? RUN_REQ : IDLE;
          is_halt_d = 1'b0;
          tmo_cnt_d = '0;
        end
      end
      IDLE: begin
        pend_halt_d = 1'b0;
        pend_run_d  = halt_go ? run_go : 1'b0;
        if (halt_go || run_go) begin
          is_halt_d = halt_go;
          tmo_cnt_d = '0;
          if (halt_go ? !sys_halt_r : sys_halt_r) state_d = halt_go ? HALT_REQ : RUN_REQ;
          else done_d = 1'b1;
        end
      end
      HALT_REQ, RUN_REQ: begin
        if (ack) state_d = ACK_WAIT_LOW;
        else if (tmo) state_d = IDLE;
        else tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      ACK_WAIT_LOW: begin
        if (!ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // requests stay high only while the FSM remains in the same request state
    halt_req_d = state_q == HALT_REQ && state_d == HALT_REQ;
    run_req_d  = state_q == RUN_REQ && state_d == RUN_REQ;
    err_d      = (in_req && !ack && tmo) | (err_q & ~clr_err);
    wake_cnt_d = (wake_cmd && sys_sleep_r) ? 4'(WAKE_CYC) :
                 (wake_cnt_q != 4'd0) ? wake_cnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_WAIT;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      wake_cnt_q  <= '0;
      pend_halt_q <= 1'b0;
      pend_run_q  <= 1'b0;
      is_halt_q   <= 1'b0;
      halt_req_q  <= 1'b0;
      run_req_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      pend_halt_q <= pend_halt_d;
      pend_run_q  <= pend_run_d;
      is_halt_q   <= is_halt_d;
      halt_req_q  <= halt_req_d;
      run_req_q   <= run_req_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  assign arc_halt_req_a = halt_req_q;
  assign arc_run_req_a  = run_req_q;
  assign arc_wake_evt_a = wake_cnt_q != 4'd0;
  assign done           = done_q;
  assign timeout_err    = err_q;
  assign state_o        = state_q;
  assign busy           = pend_halt_q | pend_run_q |
                          (state_q != IDLE && (AUTO_RUN || state_q != RST_WAIT));
endmodule

// File: tb/tb_arc_run_ctrl.sv
// tb_arc_run_ctrl: directed scenarios plus random traffic checked against a behavioural model
module tb_arc_run_ctrl;
  localparam bit AUTO_RUN = 1'b1;
  localparam int RST_DLY  = 16;
  localparam int TMO_CYC  = 2048;
  localparam int WAKE_CYC = 4;
  logic clk = 0, rst_n = 0, halt_cmd = 0, run_cmd = 0, wake_cmd = 0, clr_err = 0;
  logic arc_halt_ack = 0, arc_run_ack = 0, sys_halt_r = 0, sys_sleep_r = 0;
  logic arc_halt_req_a, arc_run_req_a, arc_wake_evt_a, busy, done, timeout_err;
  logic [2:0] state_o;
  always #5 clk = ~clk;
  arc_run_ctrl #(.AUTO_RUN(AUTO_RUN), .RST_DLY(RST_DLY), .TMO_W(12), .TMO_CYC(TMO_CYC), .WAKE_CYC(WAKE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .halt_cmd(halt_cmd), .run_cmd(run_cmd), .wake_cmd(wake_cmd),
    .clr_err(clr_err), .arc_halt_ack(arc_halt_ack), .arc_run_ack(arc_run_ack),
    .sys_halt_r(sys_halt_r), .sys_sleep_r(sys_sleep_r), .arc_halt_req_a(arc_halt_req_a),
    .arc_run_req_a(arc_run_req_a), .arc_wake_evt_a(arc_wake_evt_a), .busy(busy), .done(done),
    .timeout_err(timeout_err), .state_o(state_o)
  );
  int n_tests = 0, n_fail = 0;
  // model: phase uses the published state codes; age counts cycles spent requesting
  int m_st, m_rc, m_age, m_wake;
  bit m_kind, m_done, m_err, m_ph, m_pr;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model();
    int old;
    bit ack, tmo, hh, rr;
    if (!rst_n) begin
      m_st = 0; m_rc = 0; m_age = 0; m_wake = 0;
      m_kind = 0; m_done = 0; m_err = 0; m_ph = 0; m_pr = 0;
      return;
    end
    old = m_st; m_done = 0; tmo = 0;
    m_wake = (wake_cmd && sys_sleep_r) ? WAKE_CYC : (m_wake > 0 ? m_wake - 1 : 0);
    ack = m_kind ? arc_halt_ack : arc_run_ack;
    if (old != 1) begin
      m_ph = m_ph | halt_cmd;
      m_pr = (m_pr | run_cmd) && !(old == 3 && halt_cmd);
    end
    if (old == 0) begin
      if (m_rc == RST_DLY - 1) begin
        m_st = sys_halt_r ? 3 : 1; m_kind = 0; m_age = 0;
      end else m_rc++;
    end else if (old == 1) begin
      hh = halt_cmd | m_ph;
      rr = run_cmd | m_pr;
      if (hh) begin
        m_ph = 0; m_pr = rr; m_kind = 1; m_age = 0;
        if (!sys_halt_r) m_st = 2; else m_done = 1;
      end else if (rr) begin
        m_pr = 0; m_kind = 0; m_age = 0;
        if (sys_halt_r) m_st = 3; else m_done = 1;
      end
    end else if (old == 2 || old == 3) begin
      if (ack) m_st = 4;
      else if (m_age == TMO_CYC) begin m_st = 1; tmo = 1; end
      else m_age++;
    end else if (!ack) begin
      m_done = 1; m_st = 1;
    end
    m_err = tmo || (m_err && !clr_err);
  endtask
  task automatic compare();
    chk("state", state_o, m_st);
    chk("halt_req", arc_halt_req_a, m_st == 2 && m_age >= 1);
    chk("run_req", arc_run_req_a, m_st == 3 && m_age >= 1);
    chk("wake", arc_wake_evt_a, m_wake > 0);
    chk("busy", busy, m_st != 1 || m_ph || m_pr);
    chk("done", done, m_done);
    chk("timeout_err", timeout_err, m_err);
    chk("done_vs_req", done && (arc_halt_req_a || arc_run_req_a), 0);
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
    halt_cmd = 0; run_cmd = 0; wake_cmd = 0; clr_err = 0;
  endtask
  task automatic autorun(string tag);
    int lat = 0;
    rst_n = 1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      step();
      if (arc_run_req_a) lat = n;
    end
    chk(tag, lat, 17);
  endtask
  initial begin
    int cnt, dn, run_seen;
    bit got;
    sys_halt_r = 1;
    step(); step();
    chk("rst_busy", busy, 1);
    autorun("autorun_lat");
    repeat (4) step();
    arc_run_ack = 1;
    repeat (3) step();
    arc_run_ack = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = done;
    end
    chk("auto_done", got, 1);
    chk("auto_idle", state_o, 1);
    chk("auto_busy", busy, 0);
    sys_halt_r = 0;
    step();
    halt_cmd = 1; run_cmd = 1;
    step();
    dn = 0; run_seen = 0;
    for (int i = 0; i < 40; i++) begin
      arc_halt_ack = arc_halt_req_a;
      arc_run_ack = arc_run_req_a;
      if (arc_halt_req_a) sys_halt_r = 1;
      if (arc_run_req_a && dn == 1) run_seen = 1;
      step();
      dn += int'(done);
    end
    arc_halt_ack = 0; arc_run_ack = 0;
    chk("two_done", dn, 2);
    chk("run_after_halt", run_seen, 1);
    sys_halt_r = 0;
    halt_cmd = 1;
    step();
    cnt = 0; dn = 0;
    for (int i = 0; i < TMO_CYC + 12; i++) begin
      step();
      cnt += int'(arc_halt_req_a);
      dn += int'(done);
    end
    chk("tmo_req_cycles", cnt, TMO_CYC);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_no_done", dn, 0);
    clr_err = 1;
    step();
    chk("tmo_clr", timeout_err, 0);
    sys_halt_r = 1;
    halt_cmd = 1;
    step();
    chk("halt_ign_done", done, 1);
    chk("halt_ign_req", arc_halt_req_a, 0);
    step();
    chk("halt_ign_done2", done, 0);
    sys_sleep_r = 1;
    wake_cmd = 1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt += int'(arc_wake_evt_a);
    end
    chk("wake_4", cnt, WAKE_CYC);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      wake_cmd = (i == 0 || i == 2);
      step();
      cnt += int'(arc_wake_evt_a);
    end
    chk("wake_6", cnt, WAKE_CYC + 2);
    sys_sleep_r = 0;
    wake_cmd = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += int'(arc_wake_evt_a);
    end
    chk("wake_asleep0", cnt, 0);
    rst_n = 0;
    step();
    autorun("autorun_lat2");
    rst_n = 0;
    step();
    chk("rst_mid_req", arc_run_req_a, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_state", state_o, 0);
    autorun("autorun_lat3");
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 300) != 0;
      halt_cmd = ($urandom % 10) == 0;
      run_cmd = ($urandom % 8) == 0;
      wake_cmd = ($urandom % 12) == 0;
      clr_err = ($urandom % 20) == 0;
      if (($urandom % 4) == 0) arc_halt_ack = ~arc_halt_ack;
      if (($urandom % 4) == 0) arc_run_ack = ~arc_run_ack;
      if (($urandom % 16) == 0) sys_halt_r = ~sys_halt_r;
      sys_sleep_r = ($urandom % 2) == 1;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
